router_pkt_reader: RTL
======================

// Module: router_pkt_reader
// PURPOSE
//  Destination-side reader for one 1x3 router output port: the drain end of the per-port output FIFO.
//  - Watches vld_out and issues read_enb to pull one packet: header, payload, parity.
//  - Streams payload bytes to a local sink.
//  - Checks parity and address, and reports completion, error or abort.
//  - Starts draining as soon as data is valid, which keeps the write-side 30-cycle soft-reset watchdog from firing.
// PARAMETERS
//  PORT_ID   0   Address (0..2) this reader serves; header addr[1:0] compared against it.
// PORTS
//  clk          in   1  Clock, all logic on rising edge.
//  reset        in   1  Synchronous, active-high reset.
//  vld_out      in   1  FIFO non-empty.
//  data_out     in   8  FIFO read data, valid the cycle after read_enb.
//  soft_reset   in   1  FIFO flushed by write-side watchdog (1-cycle pulse).
//  sink_ready   in   1  Local sink can take a byte.
//  read_enb     out  1  FIFO read strobe (combinational from state, vld_out, sink_ready).
//  byte_valid   out  1  Payload byte on byte_data this cycle.
//  byte_data    out  8  Payload byte.
//  pkt_len      out  6  Length field of current/last packet.
//  busy         out  1  High in any state other than IDLE.
//  pkt_done     out  1  1-cycle pulse, packet fully read.
//  parity_err   out  1  Valid with pkt_done: received parity != computed.
//  addr_err     out  1  Valid with pkt_done: header addr != PORT_ID.
//  pkt_abort    out  1  1-cycle pulse, packet dropped on soft_reset.
// BEHAVIOUR
//  Packet format: header = {len[5:0], addr[1:0]}; then len payload bytes (0..63); then parity byte.
//  Parity is the XOR of the header and all payload bytes.
//  Reset: state=IDLE; all outputs 0; counters, parity accumulator and pkt_len cleared; read_enb forced 0.
//  Read latency: read_enb in cycle t -> data_out sampled in cycle t+1. At most one read is in flight at HDR; back-to-back reads are allowed in BODY.
//  States:
//   IDLE:
//    - read_enb = vld_out & sink_ready.
//    - On a read -> HDR.
//   HDR:
//    - No read issued.
//    - Capture the header: pkt_len=len; par=header; store addr.
//    - Set rem_issue = len+1 (payload + parity).
//    - -> BODY.
//   BODY:
//    - read_enb = vld_out & sink_ready & (rem_issue != 0); each read decrements rem_issue.
//    - Each returned byte decrements rem_rcv (also len+1).
//    - Bytes returned while rem_rcv>1 are payload: byte_valid=1, byte_data=data, par^=data.
//    - The byte returned at rem_rcv==1 is parity: compare against par.
//    - Then -> DONE.
//   DONE:
//    - pkt_done=1 for one cycle; parity_err/addr_err valid that cycle.
//    - No read issued. -> IDLE.
//  Minimum inter-packet gap: IDLE re-entered the cycle after DONE, so a new header read can issue 1 cycle after pkt_done.
//  len=0: BODY issues exactly one read (parity); no byte_valid for the packet.
//  Backpressure:
//   - sink_ready only gates read issue.
//   - A byte already in flight is still presented the next cycle; the sink must absorb one byte after dropping sink_ready.
//  vld_out low mid-packet: stall in BODY with no timeout; resume when vld_out returns.
//  soft_reset in HDR/BODY/DONE:
//   - Discard the packet and pulse pkt_abort.
//   - No pkt_done; any in-flight byte is dropped (byte_valid=0).
//   - -> IDLE; read_enb=0 that cycle.
//  soft_reset in IDLE: ignored, no pulse.
//  soft_reset coincident with DONE: the abort wins and pkt_done is suppressed.
//  reset mid-packet: immediate return to reset values; no pkt_done or pkt_abort.
//  Address mismatch is reported only; the packet is still drained.
//  Counters are 7 bits (max 64); no wrap is possible.
// TESTING
//  T1 PORT_ID=0, FIFO holds 0x0C,0x11,0x22,0x33,0x0C
//     -> byte_valid x3 with 0x11,0x22,0x33
//     -> pkt_len=3, pkt_done with parity_err=0, addr_err=0
//     -> exactly 5 read_enb cycles.
//  T2 Same packet with parity byte 0x0D -> pkt_done with parity_err=1, payload still streamed.
//  T3 Header 0x00, parity 0x00 -> 2 reads, no byte_valid, pkt_done, parity_err=0.
//  T4 len=4 packet, sink_ready low 5 cycles after 2nd payload byte
//     -> read_enb low for those cycles
//     -> at most 1 extra byte presented, all 4 bytes delivered in order, correct parity.
//  T5 soft_reset pulse during 2nd payload byte of a len=8 packet
//     -> pkt_abort=1 one cycle, busy=0 next cycle, no pkt_done
//     -> next packet read cleanly.
//  T6 PORT_ID=0, header 0x0D (addr 1, len 3), good parity -> pkt_done with addr_err=1, parity_err=0.

Source files
------------

// File: rtl/router_pkt_reader.sv
`default_nettype none
// ============================================================================
//  Module   : router_pkt_reader
//  Brief    : Drain-side reader for one router output port. Pulls one packet
//             (header, payload, parity) from the port FIFO, streams payload
//             bytes to a local sink, and reports done / parity / address /
//             abort status.
//  Revision : 1.0  initial release
// ============================================================================
module router_pkt_reader #(
  parameter int PORT_ID = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  input  logic       soft_reset,
  input  logic       sink_ready,
  output logic       read_enb,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic [5:0] pkt_len,
  output logic       busy,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       addr_err,
  output logic       pkt_abort
);

  localparam logic [1:0] C_PORT_ADDR = 2'(PORT_ID);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] rem_issue_q, rem_issue_d;   // reads still to issue (payload + parity)
  logic [6:0] rem_rcv_q, rem_rcv_d;       // bytes still to receive
  logic [7:0] par_q, par_d;               // running XOR of header and payload
  logic [1:0] addr_q, addr_d;
  logic [5:0] pkt_len_q, pkt_len_d;
  logic       inflight_q, inflight_d;     // a BODY read was issued last cycle
  logic       par_bad_q, par_bad_d;

  // Next-state, datapath updates and all outputs; outputs held at 0 in reset
  always_comb begin
    state_d     = state_q;
    rem_issue_d = rem_issue_q;
    rem_rcv_d   = rem_rcv_q;
    par_d       = par_q;
    addr_d      = addr_q;
    pkt_len_d   = pkt_len_q;
    inflight_d  = 1'b0;
    par_bad_d   = par_bad_q;
    read_enb    = 1'b0;
    byte_valid  = 1'b0;
    byte_data   = 8'd0;
    pkt_len     = 6'd0;
    busy        = 1'b0;
    pkt_done    = 1'b0;
    parity_err  = 1'b0;
    addr_err    = 1'b0;
    pkt_abort   = 1'b0;

    if (!reset) begin
      pkt_len = pkt_len_q;
      busy    = (state_q != IDLE);
      if (soft_reset && (state_q != IDLE)) begin
        // FIFO was flushed underneath us: drop the packet and any byte in flight
        pkt_abort = 1'b1;
        state_d   = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            read_enb = vld_out & sink_ready;
            if (read_enb) state_d = HDR;
          end
          HDR: begin
            pkt_len_d   = data_out[7:2];
            par_d       = data_out;
            addr_d      = data_out[1:0];
            rem_issue_d = {1'b0, data_out[7:2]} + 7'd1;
            rem_rcv_d   = {1'b0, data_out[7:2]} + 7'd1;
            state_d     = BODY;
          end
          BODY: begin
            read_enb   = vld_out & sink_ready & (rem_issue_q != 7'd0);
            inflight_d = read_enb;
            if (read_enb) rem_issue_d = rem_issue_q - 7'd1;
            if (inflight_q) begin
              rem_rcv_d = rem_rcv_q - 7'd1;
              if (rem_rcv_q > 7'd1) begin
                byte_valid = 1'b1;
                byte_data  = data_out;
                par_d      = par_q ^ data_out;
              end else begin
                // last byte of the packet is the parity byte
                par_bad_d = (data_out != par_q);
                state_d   = DONE;
              end
            end
          end
          DONE: begin
            pkt_done   = 1'b1;
            parity_err = par_bad_q;
            addr_err   = (addr_q != C_PORT_ADDR);
            state_d    = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_issue_q <= 7'd0;
      rem_rcv_q   <= 7'd0;
      par_q       <= 8'd0;
      addr_q      <= 2'd0;
      pkt_len_q   <= 6'd0;
      inflight_q  <= 1'b0;
      par_bad_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_issue_q <= rem_issue_d;
      rem_rcv_q   <= rem_rcv_d;
      par_q       <= par_d;
      addr_q      <= addr_d;
      pkt_len_q   <= pkt_len_d;
      inflight_q  <= inflight_d;
      par_bad_q   <= par_bad_d;
    end
  end

endmodule
`default_nettype wire
